// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - EX/MEM handshake, data bus and write-back bundle for mem_access
interface mem_access_if;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  memop_i;
  logic [31:0] sdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        err_o;

  modport slave (
    input  ex_valid_i, wd_i, wreg_i, wdata_i, memop_i, sdata_i, mem_ack_i, mem_rdata_i,
    output ex_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           wb_valid_o, wd_o, wreg_o, wdata_o, stallreq_o, err_o
  );

  modport master (
    output ex_valid_i, wd_i, wreg_i, wdata_i, memop_i, sdata_i, mem_ack_i, mem_rdata_i,
    input  ex_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           wb_valid_o, wd_o, wreg_o, wdata_o, stallreq_o, err_o
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: load/store bus sequencing, lane steering, write-back
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_NONE = 4'b0000, OP_LB = 4'b0001, OP_LH = 4'b0010, OP_LW = 4'b0011,
                         OP_LBU = 4'b0100, OP_LHU = 4'b0101, OP_SB = 4'b1000, OP_SH = 4'b1001,
                         OP_SW = 4'b1010;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  logic        is_load, is_store, aligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    st_be    = 4'b1111;
    st_data  = bus.sdata_i;
    case (bus.memop_i)
      OP_LB, OP_LBU:  is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; aligned = ~bus.wdata_i[0]; end
      OP_LW:         begin is_load = 1'b1; aligned = (bus.wdata_i[1:0] == 2'b00); end
      OP_SB: begin
        is_store = 1'b1;
        st_be    = 4'b0001 << bus.wdata_i[1:0];
        st_data  = {4{bus.sdata_i[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~bus.wdata_i[0];
        st_be    = 4'b0011 << bus.wdata_i[1:0];
        st_data  = {2{bus.sdata_i[15:0]}};
      end
      OP_SW: begin is_store = 1'b1; aligned = (bus.wdata_i[1:0] == 2'b00); end
      default: ;
    endcase
  end

  // Load extraction works on the offset and op latched at request time.
  always_comb begin
    ld_byte = bus.mem_rdata_i[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      op_q            <= '0;
      off_q           <= '0;
      wd_q            <= '0;
      wreg_q          <= 1'b0;
      bus.ex_ready_o  <= 1'b1;
      bus.stallreq_o  <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.mem_be_o    <= '0;
      bus.wb_valid_o  <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.wd_o        <= '0;
      bus.wreg_o      <= 1'b0;
      bus.wdata_o     <= '0;
    end else begin
      bus.wb_valid_o <= 1'b0;
      bus.err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ex_valid_i) begin
            if ((is_load || is_store) && aligned) begin
              state           <= WAIT;
              cnt             <= '0;
              op_q            <= bus.memop_i;
              off_q           <= bus.wdata_i[1:0];
              wd_q            <= bus.wd_i;
              wreg_q          <= bus.wreg_i;
              bus.ex_ready_o  <= 1'b0;
              bus.stallreq_o  <= 1'b1;
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= is_store;
              bus.mem_addr_o  <= {bus.wdata_i[31:2], 2'b00};
              bus.mem_wdata_o <= st_data;
              bus.mem_be_o    <= st_be;
            end else begin
              // NONE writes back directly; anything else left here is illegal or misaligned.
              bus.wb_valid_o <= 1'b1;
              bus.err_o      <= (bus.memop_i != OP_NONE);
              bus.wd_o       <= bus.wd_i;
              bus.wdata_o    <= bus.wdata_i;
              bus.wreg_o     <= (bus.memop_i == OP_NONE) && bus.wreg_i && (bus.wd_i != 5'd0);
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack_i || cnt == CW'(TIMEOUT - 1)) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.ex_ready_o <= 1'b1;
            bus.stallreq_o <= 1'b0;
            bus.mem_req_o  <= 1'b0;
            bus.mem_we_o   <= 1'b0;
            bus.wb_valid_o <= 1'b1;
            bus.wd_o       <= wd_q;
            if (bus.mem_ack_i) begin
              bus.wreg_o <= ~op_q[3] && wreg_q && (wd_q != 5'd0);
              if (!op_q[3]) bus.wdata_o <= ld_data;
            end else begin
              bus.err_o  <= 1'b1;
              bus.wreg_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (vector table, random model, corner sequences)
module tb_mem_access;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_if bus();
  mem_access #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  typedef struct {
    logic        req, we, unstable, hang, wb, err, wreg, extra;
    logic [31:0] addr, mwdata, wdata;
    logic [3:0]  be;
    logic [4:0]  wd;
    int          stall;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  wd;
    logic        wreg;
    int          ack_dly;
    logic        exp_req, exp_err, exp_wreg, chk_wdata;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
    int          exp_stall;
  } vec_t;

  // ack_dly = n: ack presented so that it is sampled on the n-th clock spent in WAIT; 0 = never
  task automatic txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                     input int ack_dly, output obs_t o);
    int cyc;
    o = '{default: 0};
    @(negedge clk);
    bus.ex_valid_i = 1'b1; bus.memop_i = op; bus.wdata_i = addr;
    bus.sdata_i = sdata; bus.wd_i = wd; bus.wreg_i = wreg;
    @(negedge clk);
    bus.ex_valid_i = 1'b0; bus.wdata_i = $urandom; bus.sdata_i = $urandom;
    bus.wd_i = 5'($urandom); bus.memop_i = 4'($urandom);
    if (bus.mem_req_o) begin
      o.req = 1'b1; o.addr = bus.mem_addr_o; o.be = bus.mem_be_o;
      o.mwdata = bus.mem_wdata_o; o.we = bus.mem_we_o;
      cyc = 0;
      while (bus.mem_req_o && cyc < 50) begin
        if (bus.mem_addr_o !== o.addr || bus.mem_be_o !== o.be ||
            bus.mem_wdata_o !== o.mwdata || bus.mem_we_o !== o.we) o.unstable = 1'b1;
        cyc++;
        o.stall += int'(bus.stallreq_o);
        if (cyc == ack_dly) begin bus.mem_ack_i = 1'b1; bus.mem_rdata_i = rdata; end
        @(negedge clk);
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = $urandom;
      end
      if (cyc >= 50) o.hang = 1'b1;
    end
    o.wb = bus.wb_valid_o; o.err = bus.err_o; o.wreg = bus.wreg_o;
    o.wd = bus.wd_o; o.wdata = bus.wdata_o;
    @(negedge clk);
    o.extra = bus.wb_valid_o | bus.err_o;
  endtask

  // Reference: expected behaviour derived from the op table with plain arithmetic.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                                 input int ack_dly);
    vec_t v;
    int size; bit load, store, sgn, illegal;
    logic [31:0] mask, val;
    int off;
    v = '{default: 0};
    v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.wd = wd; v.wreg = wreg; v.ack_dly = ack_dly;
    load = 0; store = 0; sgn = 0; illegal = 0; size = 4;
    case (op)
      4'd1: begin load = 1; size = 1; sgn = 1; end
      4'd2: begin load = 1; size = 2; sgn = 1; end
      4'd3: begin load = 1; size = 4; end
      4'd4: begin load = 1; size = 1; end
      4'd5: begin load = 1; size = 2; end
      4'd8: begin store = 1; size = 1; end
      4'd9: begin store = 1; size = 2; end
      4'd10: begin store = 1; size = 4; end
      4'd0: ;
      default: illegal = 1;
    endcase
    off = int'(addr % 4);
    if ((load || store) && (addr % size) != 0) illegal = 1;
    if (op == 4'd0) begin
      v.exp_wreg = wreg && (wd != 0); v.chk_wdata = 1; v.exp_wdata = addr;
    end else if (illegal) begin
      v.exp_err = 1; v.chk_wdata = 1; v.exp_wdata = addr;
    end else begin
      v.exp_req = 1;
      v.exp_stall = (ack_dly >= 1 && ack_dly <= TO) ? ack_dly : TO;
      v.exp_err = (v.exp_stall == TO && ack_dly != TO);
      v.exp_be = store ? 4'(((1 << size) - 1) << off) : 4'hF;
      v.exp_mwdata = (size == 1) ? sdata[7:0] * 32'h01010101 :
                     (size == 2) ? sdata[15:0] * 32'h00010001 : sdata;
      if (load && !v.exp_err) begin
        mask = (size == 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 1;
        val = (rdata >> (8 * off)) & mask;
        if (sgn && val >= (32'd1 << (8 * size - 1))) val = val | ~mask;
        v.exp_wdata = val; v.chk_wdata = 1;
        v.exp_wreg = wreg && (wd != 0);
      end
    end
    return v;
  endfunction

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    chk({tag, ".req"}, o.req, v.exp_req);
    chk({tag, ".wb"}, o.wb, 1'b1);
    chk({tag, ".err"}, o.err, v.exp_err);
    chk({tag, ".wreg"}, o.wreg, v.exp_wreg);
    chk({tag, ".wd"}, o.wd, v.wd);
    chk({tag, ".pulse"}, o.extra, 1'b0);
    if (v.chk_wdata) chk({tag, ".wdata"}, o.wdata, v.exp_wdata);
    if (v.exp_req && o.req) begin
      chk({tag, ".addr"}, o.addr, {v.addr[31:2], 2'b00});
      chk({tag, ".be"}, o.be, v.exp_be);
      chk({tag, ".we"}, o.we, v.op[3]);
      if (v.op[3]) chk({tag, ".mwdata"}, o.mwdata, v.exp_mwdata);
      chk({tag, ".stall"}, o.stall, v.exp_stall);
      chk({tag, ".stable"}, o.unstable, 1'b0);
      chk({tag, ".bound"}, o.hang, 1'b0);
    end
  endtask

  vec_t vecs[$];
  obs_t o;
  vec_t m;

  initial begin
    bus.ex_valid_i = 0; bus.wd_i = 0; bus.wreg_i = 0; bus.wdata_i = 0; bus.memop_i = 0;
    bus.sdata_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = 0;

    //            op    addr          sdata         rdata         wd wreg dly req err wreg chk wdata         be       mwdata        stall
    vecs.push_back('{4'h0, 32'h1234,     32'h0,        32'h0,        5, 1, 0, 0, 0, 1, 1, 32'h00001234, 4'h0, 32'h0,        0});
    vecs.push_back('{4'h1, 32'h103,      32'h0,        32'h80AABBCC, 3, 1, 3, 1, 0, 1, 1, 32'hFFFFFF80, 4'hF, 32'h0,        3});
    vecs.push_back('{4'h4, 32'h103,      32'h0,        32'h80AABBCC, 3, 1, 3, 1, 0, 1, 1, 32'h00000080, 4'hF, 32'h0,        3});
    vecs.push_back('{4'h9, 32'h102,      32'h0000BEEF, 32'h0,        7, 1, 2, 1, 0, 0, 0, 32'h0,        4'hC, 32'hBEEFBEEF, 2});
    vecs.push_back('{4'h3, 32'h101,      32'h0,        32'h0,        4, 1, 1, 0, 1, 0, 1, 32'h00000101, 4'h0, 32'h0,        0});
    vecs.push_back('{4'h7, 32'h100,      32'h0,        32'h0,        4, 1, 1, 0, 1, 0, 1, 32'h00000100, 4'h0, 32'h0,        0});
    vecs.push_back('{4'h3, 32'h200,      32'h0,        32'h0,        6, 1, 0, 1, 1, 0, 0, 32'h0,        4'hF, 32'h0,        TO});
    vecs.push_back('{4'h0, 32'h77,       32'h0,        32'h0,        0, 1, 0, 0, 0, 0, 1, 32'h00000077, 4'h0, 32'h0,        0});
    vecs.push_back('{4'h2, 32'h102,      32'h0,        32'h80011234, 8, 1, 1, 1, 0, 1, 1, 32'hFFFF8001, 4'hF, 32'h0,        1});
    vecs.push_back('{4'h5, 32'h102,      32'h0,        32'h80011234, 8, 1, 2, 1, 0, 1, 1, 32'h00008001, 4'hF, 32'h0,        2});
    vecs.push_back('{4'h8, 32'h101,      32'h12345678, 32'h0,        2, 1, 1, 1, 0, 0, 0, 32'h0,        4'h2, 32'h78787878, 1});
    vecs.push_back('{4'hA, 32'h40,       32'hCAFEF00D, 32'h0,        2, 1, 4, 1, 0, 0, 0, 32'h0,        4'hF, 32'hCAFEF00D, 4});
    vecs.push_back('{4'h3, 32'h44,       32'h0,        32'hDEADBEEF, 9, 1, 1, 1, 0, 1, 1, 32'hDEADBEEF, 4'hF, 32'h0,        1});

    repeat (2) @(negedge clk);
    chk("rst.ready", bus.ex_ready_o, 1'b1);
    chk("rst.req", bus.mem_req_o, 1'b0);
    chk("rst.stall", bus.stallreq_o, 1'b0);
    chk("rst.wb", bus.wb_valid_o, 1'b0);
    chk("rst.err", bus.err_o, 1'b0);
    chk("rst.wdata", bus.wdata_o, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata, vecs[i].wd, vecs[i].wreg, vecs[i].ack_dly, o);
      check_vec($sformatf("vec%0d", i), vecs[i], o);
      chk($sformatf("vec%0d.ready", i), bus.ex_ready_o, 1'b1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op; logic [31:0] a;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 10));
      a = $urandom;
      m = model(op, a, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, TO));
      txn(m.op, m.addr, m.sdata, m.rdata, m.wd, m.wreg, m.ack_dly, o);
      check_vec($sformatf("rnd%0d", i), m, o);
    end

    for (int k = 1; k <= 3; k++) begin
      bus.ex_valid_i = 1; bus.memop_i = 0; bus.wd_i = 5'(k); bus.wreg_i = 1; bus.wdata_i = 32'(k * 17);
      @(negedge clk);
      chk($sformatf("b2b%0d.wb", k), bus.wb_valid_o, 1'b1);
      chk($sformatf("b2b%0d.wd", k), bus.wd_o, 32'(k));
    end
    bus.ex_valid_i = 0;

    @(negedge clk);
    bus.ex_valid_i = 1; bus.memop_i = 4'h3; bus.wdata_i = 32'h10; bus.wd_i = 12; bus.wreg_i = 1;
    @(negedge clk);
    chk("hold.req", bus.mem_req_o, 1'b1);
    bus.memop_i = 4'h0; bus.wd_i = 11; bus.wdata_i = 32'h99;
    @(negedge clk);
    chk("hold.wb0", bus.wb_valid_o, 1'b0);
    chk("hold.ready", bus.ex_ready_o, 1'b0);
    @(negedge clk);
    chk("hold.wb1", bus.wb_valid_o, 1'b0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h55;
    @(negedge clk);
    bus.mem_ack_i = 0; bus.ex_valid_i = 0;
    chk("hold.wbv", bus.wb_valid_o, 1'b1);
    chk("hold.wd", bus.wd_o, 32'd12);
    chk("hold.wdata", bus.wdata_o, 32'h55);
    @(negedge clk);
    chk("hold.pulse", bus.wb_valid_o, 1'b0);

    bus.ex_valid_i = 1; bus.memop_i = 4'h3; bus.wdata_i = 32'h300; bus.wd_i = 5; bus.wreg_i = 1;
    @(negedge clk);
    bus.ex_valid_i = 0;
    chk("mrst.req_before", bus.mem_req_o, 1'b1);
    @(negedge clk);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hA5A5A5A5; rst = 1'b0;
    #1;
    chk("mrst.req", bus.mem_req_o, 1'b0);
    chk("mrst.stall", bus.stallreq_o, 1'b0);
    chk("mrst.ready", bus.ex_ready_o, 1'b1);
    chk("mrst.wd", bus.wd_o, 32'h0);
    chk("mrst.addr", bus.mem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mrst.nowb%0d", k), bus.wb_valid_o, 1'b0);
      chk($sformatf("mrst.noreq%0d", k), bus.mem_req_o, 1'b0);
    end
    bus.mem_ack_i = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for mem_ack_i before error.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ex_valid_i  input  1 and ex_ready_o  output  1: EX-to-MEM handshake; transfer when both high at a clock edge.
REQ-005 SHALL have ports wd_i  input  5 (dest reg), wreg_i  input  1 (write enable), wdata_i  input  32 (ALU result; memory address for memory ops).
REQ-006 SHALL have ports memop_i  input  4 (memory op) and sdata_i  input  32 (store data).
REQ-007 SHALL have memory-bus ports mem_req_o  output  1, mem_we_o  output  1, mem_addr_o  output  32, mem_wdata_o  output  32, mem_be_o  output  4, mem_ack_i  input  1, mem_rdata_i  input  32.
REQ-008 SHALL have write-back ports wb_valid_o  output  1, wd_o  output  5, wreg_o  output  1, wdata_o  output  32.
REQ-009 SHALL have status ports stallreq_o  output  1 (pipeline stall request) and err_o  output  1 (one-cycle error pulse).

Function
REQ-010 SHALL decode memop_i: 0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; all other codes illegal.
REQ-011 SHALL implement states IDLE and WAIT; ex_ready_o = 1 only in IDLE; stallreq_o = 1 only in WAIT.
REQ-012 On IDLE transfer with NONE: SHALL register wd/wreg/wdata to outputs, pulse wb_valid_o next cycle (latency 1), stay IDLE.
REQ-013 On IDLE transfer with legal load/store, aligned address: SHALL go WAIT, drive mem_req_o=1, mem_addr_o={wdata_i[31:2],2'b00}, mem_we_o=1 for stores only, holding all bus outputs stable until ack.
REQ-014 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=00; misaligned or illegal memop SHALL pulse err_o and wb_valid_o next cycle with wreg_o=0, no bus request.
REQ-015 Store byte lanes (little-endian): SB be=0001<<addr[1:0], data byte replicated x4; SH be=0011<<addr[1:0], halfword replicated x2; SW be=1111.
REQ-016 Loads SHALL drive mem_be_o=1111 and extract byte/halfword at addr[1:0] from mem_rdata_i; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-017 In WAIT on mem_ack_i=1: SHALL drop mem_req_o, return IDLE, pulse wb_valid_o next cycle; loads write extracted data with wreg_o=wreg_i; stores force wreg_o=0.
REQ-018 mem_ack_i SHALL be ignored in IDLE.
REQ-019 WAIT SHALL count cycles; if count reaches TIMEOUT without ack, SHALL drop mem_req_o, pulse err_o and wb_valid_o with wreg_o=0, return IDLE.
REQ-020 wd_o=0 SHALL always force wreg_o=0 (x0 never written).
REQ-021 wb_valid_o and err_o SHALL be single-cycle pulses; wd_o/wdata_o SHALL hold last value otherwise.
REQ-022 ex_valid_i SHALL be ignored while in WAIT; back-to-back transfers in IDLE SHALL be accepted every cycle.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, timeout count 0, and all outputs 0 except ex_ready_o=1 (mem_req_o/stallreq_o/wb_valid_o/err_o deasserted), including mid-WAIT; a pending ack after reset SHALL be ignored.

Verification
REQ-024 NONE, wd=5, wreg=1, wdata=0x1234 -> next cycle wb_valid_o=1, wd_o=5, wreg_o=1, wdata_o=0x1234, no mem_req_o.
REQ-025 LB addr 0x103, ack after 3 cycles with rdata 0x80AABBCC -> stallreq_o high 3 cycles, then wdata_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SH addr 0x102, sdata 0x0000BEEF -> mem_be_o=1100, mem_wdata_o=0xBEEFBEEF, mem_addr_o=0x100, wreg_o=0 at write-back.
REQ-027 LW addr 0x101 -> err_o pulse, wb_valid_o with wreg_o=0, mem_req_o never asserted; memop 0111 same response.
REQ-028 TIMEOUT=4, LW with no ack -> mem_req_o high 4 cycles, then err_o pulse, return IDLE, ex_ready_o=1.
REQ-029 rst low during WAIT with ack arriving same cycle -> all outputs reset, no wb_valid_o after release.
